arbiter_control: RTL and testbench
==================================

Name: arbiter_control

Overview:
- Control FSM that shares the single physical-memory port between the I-cache (requester A, read-only) and the D-cache (requester B, read/write).
- Drives the arbiter datapath's select/steering signals (`addrmux_sel`, `req_a`, `req_b`, `load_prefetch`).
- Generates the `mem_read`/`mem_write` strobes and per-requester responses.
- Sits between the L1 caches and the cacheline adaptor / physical memory.

Parameters:
- MAX_B_STREAK, 4: max consecutive B grants while A is pending before A is forced; must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- pmem_read_a  in  1  I-cache line read request, held until pmem_resp_a
- pmem_read_b  in  1  D-cache line read request, held until pmem_resp_b
- pmem_write_b  in  1  D-cache writeback request, held until pmem_resp_b; never with pmem_read_b
- mem_resp  in  1  physical memory completion, 1-cycle pulse
- pmem_resp_a  out  1  completion to I-cache
- pmem_resp_b  out  1  completion to D-cache
- mem_read  out  1  read strobe to physical memory
- mem_write  out  1  write strobe to physical memory
- req_a  out  1  steer mem_rdata to A
- req_b  out  1  steer mem_rdata to B
- load_prefetch  out  1  capture current mem_address into lookahead register
- addrmux_sel  out  2  0=A addr, 1=B addr, 2=lookahead+32, 3 unused
- load_pf_buf  out  1  prefetch line-buffer load strobe (0 without ARB_PREFETCH_EN)

Behaviour:
Reset and general rules:
- Reset: state=IDLE, b_streak=0. All outputs 0, addrmux_sel=0.
- rst mid-transaction abandons the access; physical memory is reset with the same rst.
- Outputs are Moore, decoded from state. Exceptions: pmem_resp_x, load_prefetch and load_pf_buf = mem_resp AND the relevant state.

States:
- IDLE: no strobes. Next-state selection:
  - A and B both pending and b_streak==MAX_B_STREAK -> SERVE_A.
  - Otherwise B pending -> SERVE_B.
  - A pending -> SERVE_A.
  - Else (prefetch feature) pf_pending -> PREFETCH.
  - Else stay.
- SERVE_A: addrmux_sel=0, req_a=1, mem_read=1.
  - On mem_resp: pmem_resp_a=1, load_prefetch=1, b_streak<=0, -> IDLE.
- SERVE_B: addrmux_sel=1, req_b=1, mem_read=pmem_read_b, mem_write=pmem_write_b.
  - On mem_resp: pmem_resp_b=1, -> IDLE.
  - b_streak increments (saturating at MAX_B_STREAK) if pmem_read_a is high at resp; otherwise clears to 0.
- PREFETCH: see Optional Feature.

Timing and boundaries:
- Latency: request sampled in IDLE; strobe asserted next cycle. At least one IDLE cycle between transactions, so a requester's dropping request is never regranted.
- Requester contract: request must stay stable until resp. A request change inside SERVE_x is not monitored; behaviour follows the state.
- A request arriving during another's service waits in IDLE arbitration.
- b_streak is 3 bits wide for the default; its width is $clog2(MAX_B_STREAK+1).

Optional Feature:
ARB_PREFETCH_EN
- Defined:
  - pf_pending flag set on SERVE_A completion.
  - PREFETCH is entered from IDLE only when neither requester is pending. It drives addrmux_sel=2 and mem_read=1, and runs to completion (no abort).
  - On mem_resp in PREFETCH: load_pf_buf=1, pf_pending<=0, -> IDLE.
  - pf_pending is cleared if SERVE_A starts before prefetch begins.
- Undefined:
  - No PREFETCH state; load_pf_buf tied 0; addrmux_sel never 2.

Decomposition:
- Package arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, SERVE_A, SERVE_B, PREFETCH}
  - constants ADDRMUX_A=2'd0, ADDRMUX_B=2'd1, ADDRMUX_PF=2'd2
- No sub-module. Single FSM plus the streak counter inline; a counter module is not justified.

Test Plan:
- Reset, then A-only read, mem_resp 5 cycles later -> mem_read, req_a, sel=0 for 5 cycles; pmem_resp_a and load_prefetch 1 cycle; back to IDLE.
- A and B both raised in the same IDLE cycle -> SERVE_B first (sel=1), then IDLE, then SERVE_A (sel=0).
- B write with mem_resp -> mem_write=1, mem_read=0, req_b=1; pmem_resp_b pulses once.
- A held high, B re-requests back-to-back, MAX_B_STREAK=4 -> exactly 4 B grants, then A granted; b_streak returns to 0.
- rst asserted in the 2nd cycle of SERVE_B -> next cycle all outputs 0, IDLE; pending A is then served normally.
- ARB_PREFETCH_EN, A read completes, no requests -> PREFETCH with sel=2, mem_read=1; mem_resp gives load_pf_buf=1. B raised during PREFETCH is granted only after it completes.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared state encoding and address-mux codes for the memory-port arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SERVE_A  = 2'd1,
      SERVE_B  = 2'd2,
      PREFETCH = 2'd3
   } arb_state_t;

   localparam logic [1:0] ADDRMUX_A  = 2'd0;
   localparam logic [1:0] ADDRMUX_B  = 2'd1;
   localparam logic [1:0] ADDRMUX_PF = 2'd2;

endpackage

// File: rtl/arbiter_control.sv
// Shares one physical-memory port between I-cache (A) and D-cache (B); strobe one cycle after IDLE sampling,
// requesters wait (held request) until their pmem_resp. ARB_PREFETCH_EN adds a next-line prefetch after A reads.
module arbiter_control
   import arb_pkg::*;
#(
   parameter int MAX_B_STREAK = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pmem_read_a,
   input  logic       pmem_read_b,
   input  logic       pmem_write_b,
   input  logic       mem_resp,
   output logic       pmem_resp_a,
   output logic       pmem_resp_b,
   output logic       mem_read,
   output logic       mem_write,
   output logic       req_a,
   output logic       req_b,
   output logic       load_prefetch,
   output logic [1:0] addrmux_sel,
   output logic       load_pf_buf
);

   localparam int SW = $clog2(MAX_B_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_B_STREAK);

   arb_state_t    state, state_nxt;
   logic [SW-1:0] b_streak, b_streak_nxt;
   logic          a_pend, b_pend;

   assign a_pend = pmem_read_a;
   assign b_pend = pmem_read_b | pmem_write_b;

`ifdef ARB_PREFETCH_EN
   logic pf_pending, pf_pending_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         b_streak <= '0;
`ifdef ARB_PREFETCH_EN
         pf_pending <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         b_streak <= b_streak_nxt;
`ifdef ARB_PREFETCH_EN
         pf_pending <= pf_pending_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      b_streak_nxt  = b_streak;
      pmem_resp_a   = 1'b0;
      pmem_resp_b   = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      req_a         = 1'b0;
      req_b         = 1'b0;
      load_prefetch = 1'b0;
      addrmux_sel   = ADDRMUX_A;
      load_pf_buf   = 1'b0;
`ifdef ARB_PREFETCH_EN
      pf_pending_nxt = pf_pending;
`endif

      case (state)
         IDLE: begin
            // B normally wins; A is forced once B has monopolised the port
            if (a_pend && b_pend && (b_streak == STREAK_MAX)) begin
               state_nxt = SERVE_A;
            end else if (b_pend) begin
               state_nxt = SERVE_B;
            end else if (a_pend) begin
               state_nxt = SERVE_A;
`ifdef ARB_PREFETCH_EN
            end else if (pf_pending) begin
               state_nxt = PREFETCH;
`endif
            end
`ifdef ARB_PREFETCH_EN
            // a fresh demand read supersedes the stale lookahead
            if (state_nxt == SERVE_A) begin
               pf_pending_nxt = 1'b0;
            end
`endif
         end

         SERVE_A: begin
            addrmux_sel = ADDRMUX_A;
            req_a       = 1'b1;
            mem_read    = 1'b1;
            if (mem_resp) begin
               pmem_resp_a   = 1'b1;
               load_prefetch = 1'b1;
               b_streak_nxt  = '0;
               state_nxt     = IDLE;
`ifdef ARB_PREFETCH_EN
               pf_pending_nxt = 1'b1;
`endif
            end
         end

         SERVE_B: begin
            addrmux_sel = ADDRMUX_B;
            req_b       = 1'b1;
            mem_read    = pmem_read_b;
            mem_write   = pmem_write_b;
            if (mem_resp) begin
               pmem_resp_b = 1'b1;
               state_nxt   = IDLE;
               if (!pmem_read_a) begin
                  b_streak_nxt = '0;
               end else if (b_streak != STREAK_MAX) begin
                  b_streak_nxt = b_streak + SW'(1);
               end
            end
         end

`ifdef ARB_PREFETCH_EN
         PREFETCH: begin
            addrmux_sel = ADDRMUX_PF;
            mem_read    = 1'b1;
            if (mem_resp) begin
               load_pf_buf    = 1'b1;
               pf_pending_nxt = 1'b0;
               state_nxt      = IDLE;
            end
         end
`endif

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_arbiter_control.sv
// Directed bench for arbiter_control: grant-level reference model checked every cycle plus literal expectations.
module tb_arbiter_control;

   localparam int MAXS = 4;
`ifdef ARB_PREFETCH_EN
   localparam bit PF_EN = 1'b1;
`else
   localparam bit PF_EN = 1'b0;
`endif

   localparam int C_RDA = 0, C_RDB = 1, C_WR = 2, C_RSA = 3, C_RSB = 4, C_LP = 5, C_PFB = 6, C_SEL2 = 7;

   logic       clk = 1'b0;
   logic       rst;
   logic       pmem_read_a, pmem_read_b, pmem_write_b, mem_resp;
   logic       pmem_resp_a, pmem_resp_b, mem_read, mem_write;
   logic       req_a, req_b, load_prefetch, load_pf_buf;
   logic [1:0] addrmux_sel;
   logic [9:0] outs;

   always #5 clk = ~clk;

   arbiter_control #(.MAX_B_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .pmem_read_a(pmem_read_a), .pmem_read_b(pmem_read_b), .pmem_write_b(pmem_write_b),
      .mem_resp(mem_resp),
      .pmem_resp_a(pmem_resp_a), .pmem_resp_b(pmem_resp_b),
      .mem_read(mem_read), .mem_write(mem_write),
      .req_a(req_a), .req_b(req_b), .load_prefetch(load_prefetch),
      .addrmux_sel(addrmux_sel), .load_pf_buf(load_pf_buf)
   );

   assign outs = {pmem_resp_a, pmem_resp_b, mem_read, mem_write, req_a, req_b,
                  load_prefetch, addrmux_sel, load_pf_buf};

   int    checks = 0;
   int    errors = 0;
   int    cnt [8];
   int    snap [8];
   string grants = "";
   int    gsnap = 0;
   int    mem_lat = 5;

   // model: who owns the port (0 none, 1 A, 2 B, 3 prefetch), B grants in a row while A waited
   int m_owner = 0;
   int m_bcount = 0;
   bit m_pf = 1'b0;
   bit m_live = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got grants '%s', required '%s'", name, act, exp);
      end
   endtask

   function automatic logic [9:0] model_out();
      logic       rsa, rsb, rd, wr, ra, rb, lp, pfb;
      logic [1:0] sel;
      {rsa, rsb, rd, wr, ra, rb, lp, pfb} = '0;
      sel = 2'd0;
      case (m_owner)
         1: begin ra = 1'b1; rd = 1'b1; rsa = mem_resp; lp = mem_resp; end
         2: begin rb = 1'b1; rd = pmem_read_b; wr = pmem_write_b; rsb = mem_resp; sel = 2'd1; end
         3: begin rd = 1'b1; sel = 2'd2; pfb = mem_resp; end
         default: ;
      endcase
      return {rsa, rsb, rd, wr, ra, rb, lp, sel, pfb};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_owner = 0; m_bcount = 0; m_pf = 1'b0; m_live = 1'b1;
         end else if (m_owner == 0) begin
            if ((pmem_read_b || pmem_write_b) && !(pmem_read_a && m_bcount >= MAXS)) begin
               m_owner = 2;
            end else if (pmem_read_a) begin
               m_owner = 1; m_pf = 1'b0;
            end else if (PF_EN && m_pf) begin
               m_owner = 3;
            end
         end else if (mem_resp) begin
            if (m_owner == 1) begin
               m_bcount = 0; m_pf = PF_EN;
            end else if (m_owner == 2) begin
               m_bcount = pmem_read_a ? ((m_bcount + 1 > MAXS) ? MAXS : m_bcount + 1) : 0;
            end else begin
               m_pf = 1'b0;
            end
            m_owner = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_live) check("cycle outputs", 32'(outs), 32'(model_out()));
      end
   end

   initial begin
      bit pa = 1'b0, pb = 1'b0, pp = 1'b0, pfg;
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      forever begin
         @(negedge clk);
         if (mem_read === 1'b1 && req_a === 1'b1) cnt[C_RDA]++;
         if (mem_read === 1'b1 && req_b === 1'b1) cnt[C_RDB]++;
         if (mem_write === 1'b1) cnt[C_WR]++;
         if (pmem_resp_a === 1'b1) cnt[C_RSA]++;
         if (pmem_resp_b === 1'b1) cnt[C_RSB]++;
         if (load_prefetch === 1'b1) cnt[C_LP]++;
         if (load_pf_buf === 1'b1) cnt[C_PFB]++;
         if (addrmux_sel === 2'd2) cnt[C_SEL2]++;
         pfg = (addrmux_sel === 2'd2) && (mem_read === 1'b1);
         if (req_a === 1'b1 && !pa) grants = {grants, "A"};
         if (req_b === 1'b1 && !pb) grants = {grants, "B"};
         if (pfg && !pp) grants = {grants, "P"};
         pa = (req_a === 1'b1);
         pb = (req_b === 1'b1);
         pp = pfg;
      end
   end

   // physical memory: answers mem_lat cycles after a strobe appears
   initial begin
      int c = 0;
      mem_resp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_resp) begin
            mem_resp = 1'b0; c = 0;
         end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
            c++;
            if (c >= mem_lat) mem_resp = 1'b1;
         end else begin
            c = 0;
         end
      end
   end

   function automatic bit sig(input int which);
      case (which)
         0: return pmem_resp_a === 1'b1;
         1: return pmem_resp_b === 1'b1;
         2: return addrmux_sel === 2'd2;
         default: return req_b === 1'b1;
      endcase
   endfunction

   task automatic wait_sig(input int which, input string name);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (sig(which)) got = 1'b1;
      end
      check({name, " arrives"}, 32'(got), 32'd1);
   endtask

   task automatic serve_a(input int n);
      pmem_read_a = 1'b1;
      for (int i = 0; i < n; i++) wait_sig(0, "pmem_resp_a");
      @(posedge clk);
      #1 pmem_read_a = 1'b0;
   endtask

   task automatic serve_b(input int n, input bit wr);
      if (wr) pmem_write_b = 1'b1; else pmem_read_b = 1'b1;
      for (int i = 0; i < n; i++) wait_sig(1, "pmem_resp_b");
      @(posedge clk);
      #1;
      pmem_read_b  = 1'b0;
      pmem_write_b = 1'b0;
   endtask

   task automatic take_snap();
      for (int k = 0; k < 8; k++) snap[k] = cnt[k];
      gsnap = grants.len();
   endtask

   function automatic string new_grants();
      return grants.substr(gsnap, grants.len() - 1);
   endfunction

   task automatic quiesce();
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      pmem_read_a = 1'b0; pmem_read_b = 1'b0; pmem_write_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", 32'(outs), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle outputs", 32'(outs), 32'd0);
      @(posedge clk);
      #1;

      // A-only read
      take_snap();
      serve_a(1);
      check_str("a only grant", new_grants(), "A");
      check("a read cycles", 32'(cnt[C_RDA] - snap[C_RDA]), 32'd5);
      check("a resp pulses", 32'(cnt[C_RSA] - snap[C_RSA]), 32'd1);
      check("load_prefetch pulses", 32'(cnt[C_LP] - snap[C_LP]), 32'd1);
      quiesce();

      // simultaneous A and B: B first
      take_snap();
      fork
         serve_a(1);
         serve_b(1, 1'b0);
      join
      check_str("a+b same cycle order", new_grants(), "BA");
      quiesce();

      // B writeback
      take_snap();
      serve_b(1, 1'b1);
      check_str("b write grant", new_grants(), "B");
      check("b write cycles", 32'(cnt[C_WR] - snap[C_WR]), 32'd5);
      check("b write no read", 32'(cnt[C_RDB] - snap[C_RDB]), 32'd0);
      check("b resp pulses", 32'(cnt[C_RSB] - snap[C_RSB]), 32'd1);
      quiesce();

      // B streak limit, then streak cleared by the A service
      take_snap();
      fork
         serve_a(2);
         serve_b(5, 1'b0);
      join
      check_str("b streak fairness", new_grants(), "BBBBABA");
      quiesce();

      // reset in the second SERVE_B cycle with A waiting
      take_snap();
      pmem_read_a = 1'b1;
      pmem_read_b = 1'b1;
      wait_sig(3, "req_b");
      @(posedge clk);
      #1;
      rst = 1'b1;
      pmem_read_b = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("outputs after mid-b reset", 32'(outs), 32'd0);
      wait_sig(0, "pmem_resp_a after reset");
      @(posedge clk);
      #1 pmem_read_a = 1'b0;
      check_str("reset abandons b", new_grants(), "BA");
      check("no b resp after reset", 32'(cnt[C_RSB] - snap[C_RSB]), 32'd0);
      quiesce();

      // prefetch after an idle-following A read
      take_snap();
      serve_a(1);
`ifdef ARB_PREFETCH_EN
      wait_sig(2, "prefetch select");
      @(posedge clk);
      #1;
      serve_b(1, 1'b0);
      check_str("prefetch then b", new_grants(), "APB");
      check("load_pf_buf pulses", 32'(cnt[C_PFB] - snap[C_PFB]), 32'd1);
      check("prefetch select cycles", 32'(cnt[C_SEL2] - snap[C_SEL2]), 32'd5);
`else
      quiesce();
      check_str("no prefetch", new_grants(), "A");
      check("load_pf_buf stays 0", 32'(cnt[C_PFB] - snap[C_PFB]), 32'd0);
      check("select never 2", 32'(cnt[C_SEL2] - snap[C_SEL2]), 32'd0);
`endif
      quiesce();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
